// File: rtl/wb_uart_arbiter_pkg.sv
// Shared definitions for the two-master Wishbone arbiter in front of the UART slave.
package wb_uart_arbiter_pkg;

    localparam int DAT_W = 32;
    localparam int SEL_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2,
        ST_DRAIN  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Stall counter for a strobed slave access; expired pulses in the TIMEOUT-th stalled cycle.
module wb_timeout_ctr #(
    parameter int TIMEOUT = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (run) begin
            count <= count + 1'b1;
        end
    end

    // A zero TIMEOUT leaves the counter free-running and never reports expiry.
    generate
        if (TIMEOUT == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_on
            assign expired = run && (count == CW'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/wb_uart_arbiter.sv
// Round-robin arbiter sharing the UART Wishbone slave between the CPU (m0) and debug (m1) ports.
// Handshake: a master requests with cyc&stb; the granted master sees the slave's ack/data combinationally.
module wb_uart_arbiter
    import wb_uart_arbiter_pkg::*;
#(
    parameter int ADR_W   = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ADR_W-1:0] m0_adr_i,
    input  logic [DAT_W-1:0] m0_dat_i,
    input  logic             m0_we_i,
    input  logic [SEL_W-1:0] m0_sel_i,
    input  logic             m0_stb_i,
    input  logic             m0_cyc_i,
    output logic             m0_ack_o,
    output logic             m0_err_o,
    output logic [DAT_W-1:0] m0_dat_o,
    input  logic [ADR_W-1:0] m1_adr_i,
    input  logic [DAT_W-1:0] m1_dat_i,
    input  logic             m1_we_i,
    input  logic [SEL_W-1:0] m1_sel_i,
    input  logic             m1_stb_i,
    input  logic             m1_cyc_i,
    output logic             m1_ack_o,
    output logic             m1_err_o,
    output logic [DAT_W-1:0] m1_dat_o,
    output logic [ADR_W-1:0] s_adr_o,
    output logic [DAT_W-1:0] s_dat_o,
    output logic             s_we_o,
    output logic [SEL_W-1:0] s_sel_o,
    output logic             s_stb_o,
    output logic             s_cyc_o,
    input  logic             s_ack_i,
    input  logic [DAT_W-1:0] s_dat_i,
    output logic [1:0]       dbg_state
);

    arb_state_e state, state_nxt;
    logic       prio, prio_nxt;
    logic       req0, req1;
    logic       gnt0, gnt1, granted;
    logic       sel_cyc, sel_stb;
    logic       tmo_run, tmo_clr, expired;

    assign req0    = m0_cyc_i & m0_stb_i;
    assign req1    = m1_cyc_i & m1_stb_i;
    assign gnt0    = (state == ST_GRANT0);
    assign gnt1    = (state == ST_GRANT1);
    assign granted = gnt0 | gnt1;
    assign sel_cyc = gnt1 ? m1_cyc_i : m0_cyc_i;
    assign sel_stb = gnt1 ? m1_stb_i : m0_stb_i;

    // A same-cycle ack suppresses counting, so ack always beats expiry.
    assign tmo_run = granted & sel_cyc & sel_stb & ~s_ack_i;
    assign tmo_clr = ~granted | ~sel_cyc | ~sel_stb | s_ack_i;

    wb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .run     (tmo_run),
        .clr     (tmo_clr),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            prio  <= 1'b0;
        end else begin
            state <= state_nxt;
            prio  <= prio_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        prio_nxt  = prio;
        unique case (state)
            ST_IDLE: begin
                if (req0 && req1) begin
                    state_nxt = prio ? ST_GRANT1 : ST_GRANT0;
                end else if (req0) begin
                    state_nxt = ST_GRANT0;
                end else if (req1) begin
                    state_nxt = ST_GRANT1;
                end
            end
            ST_GRANT0: begin
                if (!m0_cyc_i) begin
                    state_nxt = ST_IDLE;
                    prio_nxt  = 1'b1;
                end else if (expired) begin
                    state_nxt = ST_DRAIN;
                    prio_nxt  = 1'b1;
                end
            end
            ST_GRANT1: begin
                if (!m1_cyc_i) begin
                    state_nxt = ST_IDLE;
                    prio_nxt  = 1'b0;
                end else if (expired) begin
                    state_nxt = ST_DRAIN;
                    prio_nxt  = 1'b0;
                end
            end
            ST_DRAIN: begin
                // The UART finishes the abandoned transfer; its ack is swallowed here.
                if (s_ack_i) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_stb_o  = 1'b0;
        s_cyc_o  = 1'b0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m0_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m1_dat_o = '0;
        if (gnt0) begin
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            s_we_o   = m0_we_i;
            s_sel_o  = m0_sel_i;
            s_stb_o  = m0_stb_i;
            s_cyc_o  = m0_cyc_i;
            m0_ack_o = s_ack_i;
            m0_err_o = expired;
            m0_dat_o = s_dat_i;
        end else if (gnt1) begin
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            s_we_o   = m1_we_i;
            s_sel_o  = m1_sel_i;
            s_stb_o  = m1_stb_i;
            s_cyc_o  = m1_cyc_i;
            m1_ack_o = s_ack_i;
            m1_err_o = expired;
            m1_dat_o = s_dat_i;
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_wb_uart_arbiter.sv
// Random-stimulus bench for wb_uart_arbiter: bus-level arbitration model plus per-master response scoreboard.
module tb_wb_uart_arbiter;

    localparam int ADR_W = 16;
    localparam int T     = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] adr [2];
    logic [31:0] dat [2];
    logic        we  [2];
    logic [3:0]  sel [2];
    logic        stb [2];
    logic        cyc [2];
    logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic [31:0] m0_dat_o, m1_dat_o;
    logic [15:0] s_adr_o;
    logic [31:0] s_dat_o;
    logic        s_we_o, s_stb_o, s_cyc_o;
    logic [3:0]  s_sel_o;
    logic        s_ack_i;
    logic [31:0] s_dat_i;
    logic [1:0]  dbg_state;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [32:0] exp_q0[$];
    logic [32:0] exp_q1[$];
    int          slot_d  [2];
    logic [31:0] slot_rd [2];
    bit          late_pending;

    always #5 clk = ~clk;

    wb_uart_arbiter #(.ADR_W(ADR_W), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .m0_adr_i(adr[0]), .m0_dat_i(dat[0]), .m0_we_i(we[0]), .m0_sel_i(sel[0]),
        .m0_stb_i(stb[0]), .m0_cyc_i(cyc[0]),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_dat_o(m0_dat_o),
        .m1_adr_i(adr[1]), .m1_dat_i(dat[1]), .m1_we_i(we[1]), .m1_sel_i(sel[1]),
        .m1_stb_i(stb[1]), .m1_cyc_i(cyc[1]),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_dat_o(m1_dat_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o),
        .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
        .dbg_state(dbg_state)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One master transaction group: cyc held across n strobes, each with a chosen slave delay.
    task automatic master_burst(input int m, input int n, input int fixed_d);
        int          d;
        int          waits;
        logic [31:0] rd;
        bit          done;
        bit          got_err;
        @(posedge clk); #1;
        cyc[m] = 1'b1;
        for (int k = 0; k < n; k++) begin
            if (fixed_d >= 0) d = fixed_d;
            else if ($urandom_range(0, 3) == 0) d = $urandom_range(T - 2, T + 3);
            else d = $urandom_range(0, 4);
            rd = $urandom;
            slot_d[m]  = d;
            slot_rd[m] = rd;
            adr[m] = {m[0], 15'($urandom)};
            dat[m] = $urandom;
            we[m]  = 1'($urandom_range(0, 1));
            sel[m] = 4'($urandom_range(1, 15));
            // Ack lands in stalled cycle d+1; the slave wins only if that is within T cycles.
            if (m == 0) exp_q0.push_back((d <= T - 1) ? {1'b0, rd} : {1'b1, 32'h0});
            else        exp_q1.push_back((d <= T - 1) ? {1'b0, rd} : {1'b1, 32'h0});
            stb[m] = 1'b1;
            done = 1'b0; got_err = 1'b0; waits = 0;
            while (!done) begin
                @(negedge clk); #3;
                done    = (m == 0) ? (m0_ack_o | m0_err_o) : (m1_ack_o | m1_err_o);
                got_err = (m == 0) ? m0_err_o : m1_err_o;
                waits++;
                if (!done && waits > 400) begin
                    chk("master_wait_budget", 64'(waits), 64'(400));
                    done = 1'b1; got_err = 1'b1;
                end
            end
            @(posedge clk); #1;
            stb[m] = 1'b0;
            if (got_err) break;
            if (k < n - 1) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        cyc[m] = 1'b0;
    endtask

    // Slave model: acks after slot_d stalled cycles; an abandoned transfer gets a late ack.
    initial begin : responder
        int cnt;
        int late_wait;
        int id;
        bit active;
        s_ack_i = 1'b0; s_dat_i = '0; late_pending = 1'b0; active = 1'b0; cnt = 0; late_wait = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                s_ack_i = 1'b0; active = 1'b0; late_pending = 1'b0; cnt = 0;
                continue;
            end
            if (s_ack_i && late_pending) late_pending = 1'b0;
            s_ack_i = 1'b0;
            s_dat_i = $urandom;
            if (late_pending) begin
                if (late_wait == 0) s_ack_i = 1'b1; else late_wait--;
            end else if (active && !(s_stb_o && s_cyc_o)) begin
                active = 1'b0;
                late_pending = 1'b1;
                late_wait = $urandom_range(0, 3);
                if (late_wait == 0) s_ack_i = 1'b1; else late_wait--;
            end else if (s_stb_o && s_cyc_o) begin
                id = int'(s_adr_o[15]);
                if (!active) begin active = 1'b1; cnt = 0; end
                chk("s_adr_route", 64'(s_adr_o), 64'(adr[id]));
                chk("s_dat_route", 64'(s_dat_o), 64'(dat[id]));
                chk("s_we_route",  64'(s_we_o),  64'(we[id]));
                chk("s_sel_route", 64'(s_sel_o), 64'(sel[id]));
                if (cnt == slot_d[id]) begin
                    s_ack_i = 1'b1; s_dat_i = slot_rd[id]; active = 1'b0;
                end else begin
                    cnt++;
                end
            end
        end
    end

    task automatic check_master(input int m, input logic ack, input logic err, input logic [31:0] d,
                                input bit granted, input bit skip, input int stall);
        logic [32:0] e;
        if (skip) return;
        if (!granted) begin
            chk($sformatf("m%0d_idle_out", m), {31'h0, ack, err, d}, 64'h0);
        end else if (ack || err) begin
            chk($sformatf("m%0d_ack_err_excl", m), 64'(ack & err), 64'h0);
            chk($sformatf("m%0d_resp_pending", m), 64'((m == 0) ? exp_q0.size() != 0 : exp_q1.size() != 0), 64'h1);
            if (m == 0 && exp_q0.size() != 0) e = exp_q0.pop_front();
            else if (m == 1 && exp_q1.size() != 0) e = exp_q1.pop_front();
            else e = 33'h0;
            chk($sformatf("m%0d_resp", m), 64'({err, ack ? d : 32'h0}), 64'(e));
            if (err) chk($sformatf("m%0d_err_stall_cycles", m), 64'(stall), 64'(T));
        end
    endtask

    // Bus-level monitor: arbitration decisions from round-robin rules, then per-master responses.
    initial begin : monitor
        bit   prev_scyc, prev_idle, prev_err, exp_any, idle_now, r0, r1, fall_grant;
        int   exp_id, prev_id, stall;
        logic prio_m;
        prev_scyc = 0; prev_idle = 0; prev_err = 0; exp_any = 0; exp_id = 0; prev_id = 0;
        stall = 0; prio_m = 1'b0;
        forever begin
            @(negedge clk); #3;
            if (rst) begin
                prev_scyc = 0; prev_idle = 0; prev_err = 0; stall = 0; prio_m = 1'b0;
                continue;
            end
            if (prev_idle) begin
                chk("grant_valid", 64'(s_cyc_o), 64'(exp_any));
                if (exp_any && s_cyc_o) chk("grant_owner", 64'(s_adr_o[15]), 64'(exp_id));
            end
            if (late_pending) chk("drain_hold", 64'(s_cyc_o), 64'h0);
            if (s_cyc_o) chk("s_stb_route", 64'(s_stb_o), 64'(stb[int'(s_adr_o[15])]));
            stall = (s_cyc_o && s_stb_o && !s_ack_i) ? stall + 1 : 0;
            fall_grant = prev_scyc && !s_cyc_o && !prev_err;
            check_master(0, m0_ack_o, m0_err_o, m0_dat_o, s_cyc_o && !s_adr_o[15],
                         fall_grant && prev_id == 0, stall);
            check_master(1, m1_ack_o, m1_err_o, m1_dat_o, s_cyc_o && s_adr_o[15],
                         fall_grant && prev_id == 1, stall);
            if (prev_scyc && !s_cyc_o) prio_m = (prev_id == 0);
            idle_now = !s_cyc_o && !prev_scyc && !late_pending;
            r0 = cyc[0] & stb[0];
            r1 = cyc[1] & stb[1];
            exp_any = r0 | r1;
            exp_id  = (r0 && r1) ? int'(prio_m) : (r1 ? 1 : 0);
            prev_idle = idle_now;
            prev_err  = m0_err_o | m1_err_o;
            prev_scyc = s_cyc_o;
            prev_id   = int'(s_adr_o[15]);
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_s_req"}, {s_adr_o, s_dat_o, s_we_o, s_sel_o, s_stb_o, s_cyc_o}, 64'h0);
        chk({tag, "_m0_out"}, {m0_ack_o, m0_err_o, m0_dat_o}, 64'h0);
        chk({tag, "_m1_out"}, {m1_ack_o, m1_err_o, m1_dat_o}, 64'h0);
        chk({tag, "_state"}, 64'(dbg_state), 64'h0);
    endtask

    initial begin : watchdog
        #400000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin : main
        int waits;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            adr[i] = {i[0], 15'h0}; dat[i] = '0; we[i] = 1'b0; sel[i] = '0; stb[i] = 1'b0; cyc[i] = 1'b0;
            slot_d[i] = 0; slot_rd[i] = '0;
        end
        #2;
        check_all_zero("reset");
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        master_burst(0, 1, 3);
        repeat (2) begin
            fork
                master_burst(0, 1, -1);
                master_burst(1, 1, -1);
            join
        end
        fork
            master_burst(1, 2, 2);
            begin repeat (3) @(posedge clk); master_burst(0, 1, 1); end
        join
        fork
            master_burst(0, 1, T + 4);
            begin @(posedge clk); master_burst(1, 1, 0); end
        join
        master_burst(0, 1, T - 1);
        master_burst(1, 1, T);
        master_burst(1, 1, T - 1);

        fork
            begin
                repeat (20) begin
                    repeat ($urandom_range(0, 4)) @(posedge clk);
                    master_burst(0, $urandom_range(1, 3), -1);
                end
            end
            begin
                repeat (20) begin
                    repeat ($urandom_range(0, 4)) @(posedge clk);
                    master_burst(1, $urandom_range(1, 3), -1);
                end
            end
        join
        repeat (6) @(posedge clk);

        // Reset while m1 holds the bus, then a simultaneous request must favour m0 again.
        slot_d[1] = 1000;
        @(posedge clk); #1;
        adr[1] = 16'h8123; dat[1] = 32'hCAFE_0001; we[1] = 1'b1; sel[1] = 4'hF;
        cyc[1] = 1'b1; stb[1] = 1'b1;
        waits = 0;
        do begin
            @(negedge clk); #3;
            waits++;
        end while (!(s_cyc_o && s_adr_o[15]) && waits < 20);
        chk("rst_test_m1_granted", 64'(s_cyc_o && s_adr_o[15]), 64'h1);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        cyc[1] = 1'b0; stb[1] = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b0;
        fork
            master_burst(0, 1, 2);
            master_burst(1, 1, 2);
        join
        repeat (6) @(posedge clk);

        chk("exp_q0_drained", 64'(exp_q0.size()), 64'h0);
        chk("exp_q1_drained", 64'(exp_q1.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
